// File: rtl/acc_stream_pkg.sv
// Shared sizes and FSM state constants for the accelerator host streamer.
package acc_stream_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 16;
  localparam int IFMAP_WORDS  = 32;
  localparam int WEIGHT_WORDS = 1024;
  localparam int BIAS_WORDS   = 128;
  localparam int OUT_WORDS    = 128;
  localparam int TOTAL_WORDS  = IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_DRAIN   = 3'd2;
  localparam state_t ST_COLLECT = 3'd3;
  localparam state_t ST_FIN     = 3'd4;

endpackage

// File: rtl/acc_result_writer.sv
// Captures accelerator result words into memory at OUT_BASE upward, flags overflow.
// Optional STREAM_CHECKSUM_EN adds rx_sum_o, the sum of all captured words.
module acc_result_writer #(
  parameter int DATA_W    = acc_stream_pkg::DATA_W,
  parameter int ADDR_W    = acc_stream_pkg::ADDR_W,
  parameter int OUT_WORDS = acc_stream_pkg::OUT_WORDS,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              active_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              err_ovf_o
`ifdef STREAM_CHECKSUM_EN
  , output logic [DATA_W-1:0] rx_sum_o
`endif
);

  localparam int WCW = $clog2(OUT_WORDS + 1);
  localparam logic [WCW-1:0] WR_MAX = WCW'(OUT_WORDS);

  logic [WCW-1:0]    cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ovf_q;
  logic              take;
  logic              drop;

  // Count saturates at OUT_WORDS; anything beyond is dropped and flagged.
  assign take = active_i & valid_i & (cnt_q != WR_MAX);
  assign drop = active_i & valid_i & (cnt_q == WR_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_en_q <= take;
      if (clear_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (take) begin
          cnt_q  <= cnt_q + 1'b1;
          addr_q <= OUT_BASE + ADDR_W'(cnt_q);
          data_q <= data_i;
        end
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

`ifdef STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] rx_sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sum_q <= '0;
    else if (clear_i) rx_sum_q <= '0;
    else if (take) rx_sum_q <= rx_sum_q + data_i;
  end

  assign rx_sum_o = rx_sum_q;
`endif

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign err_ovf_o = ovf_q;

endmodule

// File: rtl/acc_host_streamer.sv
// Host-side streamer: reads the input image from memory, streams it gap-free to the
// accelerator, writes results back. Optional STREAM_CHECKSUM_EN adds tx_sum / rx_sum.
module acc_host_streamer #(
  parameter int DATA_W       = acc_stream_pkg::DATA_W,
  parameter int ADDR_W       = acc_stream_pkg::ADDR_W,
  parameter int IFMAP_WORDS  = acc_stream_pkg::IFMAP_WORDS,
  parameter int WEIGHT_WORDS = acc_stream_pkg::WEIGHT_WORDS,
  parameter int BIAS_WORDS   = acc_stream_pkg::BIAS_WORDS,
  parameter int OUT_WORDS    = acc_stream_pkg::OUT_WORDS,
  parameter logic [ADDR_W-1:0] IN_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_in,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              err_early,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              acc_mode,
  output logic              acc_ready,
  output logic              acc_i_en,
  output logic [DATA_W-1:0] acc_data_in,
  input  logic              acc_valid,
  input  logic [DATA_W-1:0] acc_ofmap,
  input  logic              acc_done,
  output logic [2:0]        dbg_state
`ifdef STREAM_CHECKSUM_EN
  , output logic [DATA_W-1:0] tx_sum
  , output logic [DATA_W-1:0] rx_sum
`endif
);

  import acc_stream_pkg::*;

  localparam int TOTAL = IFMAP_WORDS + WEIGHT_WORDS + BIAS_WORDS;
  localparam int RCW   = $clog2(TOTAL + 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(TOTAL - 1);

  state_t         state_q, state_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic           mode_q, mode_d;
  logic           err_early_q, err_early_d;
  logic           ready_q;
  logic           start_ok;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    mode_d      = mode_q;
    err_early_d = err_early_q;
    start_ok    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        start_ok    = 1'b1;
        mode_d      = mode_in;
        rd_cnt_d    = '0;
        err_early_d = 1'b0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == RD_LAST) state_d = ST_DRAIN;
        if (acc_done) err_early_d = 1'b1;
      end
      // An early acc_done only flags; COLLECT still waits for a fresh one.
      ST_DRAIN: begin
        state_d = ST_COLLECT;
        if (acc_done) err_early_d = 1'b1;
      end
      ST_COLLECT: if (acc_done) state_d = ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_cnt_q    <= '0;
      mode_q      <= 1'b0;
      err_early_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      mode_q      <= mode_d;
      err_early_q <= err_early_d;
      ready_q     <= mem_rd_en;
    end
  end

  // Memory returns data one cycle after the strobe, so the delayed strobe marks it valid.
  assign mem_rd_en   = (state_q == ST_LOAD);
  assign mem_rd_addr = mem_rd_en ? IN_BASE + ADDR_W'(rd_cnt_q) : '0;
  assign acc_ready   = ready_q;
  assign acc_data_in = ready_q ? mem_rd_data : '0;
  assign busy        = (state_q != ST_IDLE);
  assign acc_i_en    = busy;
  assign done        = (state_q == ST_FIN);
  assign acc_mode    = mode_q;
  assign err_early   = err_early_q;
  assign dbg_state   = state_q;

`ifdef STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] tx_sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_sum_q <= '0;
    else if (start_ok) tx_sum_q <= '0;
    else if (ready_q) tx_sum_q <= tx_sum_q + acc_data_in;
  end

  assign tx_sum = tx_sum_q;
`endif

  acc_result_writer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .OUT_WORDS(OUT_WORDS),
    .OUT_BASE (OUT_BASE)
  ) u_writer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_ok),
    .active_i (busy),
    .valid_i  (acc_valid),
    .data_i   (acc_ofmap),
    .wr_en_o  (mem_wr_en),
    .wr_addr_o(mem_wr_addr),
    .wr_data_o(mem_wr_data),
    .err_ovf_o(err_ovf)
`ifdef STREAM_CHECKSUM_EN
    , .rx_sum_o(rx_sum)
`endif
  );

endmodule
